// File: rtl/pulse_capture.sv
// Input-capture unit: measures the width of a pulse on an asynchronous input in
// prescaled ticks and hands the result to a consumer over valid/ready.
module pulse_capture #(
    parameter int COUNT_BITS  = 16,
    parameter int SCALER_BITS = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [SCALER_BITS-1:0] ps,
    input  logic                   edge_sel,
    input  logic                   sig_in,
    output logic                   busy,
    output logic                   cap_valid,
    input  logic                   cap_ready,
    output logic [COUNT_BITS-1:0]  cap_value,
    output logic                   cap_ovf
);

    // Wide enough to hold (1 << ps) - 1 for the largest encodable ps.
    localparam int SCALE_W = 1 << SCALER_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_MEASURE,
        ST_HOLD
    } state_t;

    state_t                   state_reg, state_next;
    logic [SYNC_STAGES-1:0]   sync_reg;
    logic                     hist_reg;
    logic [SCALER_BITS-1:0]   ps_l_reg;
    logic                     edge_sel_l_reg;
    logic                     seen_idle_reg;
    logic [SCALE_W-1:0]       scaler_reg;
    logic [COUNT_BITS-1:0]    counter_reg;
    logic                     ovf_int_reg;
    logic [COUNT_BITS-1:0]    cap_value_reg;
    logic                     cap_ovf_reg;

    logic                     level;
    logic                     edge_det;
    logic                     start_edge;
    logic                     stop_edge;
    logic                     enter_armed;
    logic [SCALE_W-1:0]       scaler_limit;
    logic                     tick;
    logic                     count_sat;
    logic [COUNT_BITS-1:0]    counter_now;

    assign level    = sync_reg[SYNC_STAGES-1];
    assign edge_det = level ^ hist_reg;

    // edge_sel_l_reg is also the inactive level: 0 for high pulses, 1 for low pulses.
    assign start_edge = edge_det && (level != edge_sel_l_reg) && seen_idle_reg;
    assign stop_edge  = edge_det && (level == edge_sel_l_reg);

    assign scaler_limit = (SCALE_W'(1) << ps_l_reg) - SCALE_W'(1);
    assign tick         = (scaler_reg == scaler_limit);
    assign count_sat    = tick && (&counter_reg);
    assign counter_now  = (tick && !count_sat) ? counter_reg + COUNT_BITS'(1) : counter_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enable) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable)        state_next = ST_IDLE;
                else if (start_edge) state_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (!enable)        state_next = ST_IDLE;
                else if (stop_edge) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (cap_ready) state_next = enable ? ST_ARMED : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign enter_armed = (state_next == ST_ARMED) && (state_reg != ST_ARMED);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            sync_reg       <= '0;
            hist_reg       <= 1'b0;
            ps_l_reg       <= '0;
            edge_sel_l_reg <= 1'b0;
            seen_idle_reg  <= 1'b0;
            scaler_reg     <= '0;
            counter_reg    <= '0;
            ovf_int_reg    <= 1'b0;
            cap_value_reg  <= '0;
            cap_ovf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            hist_reg  <= level;

            // Configuration is frozen for the whole arm/measure/hold cycle.
            if (enter_armed) begin
                ps_l_reg       <= ps;
                edge_sel_l_reg <= edge_sel;
                seen_idle_reg  <= 1'b0;
            end else if (state_reg == ST_ARMED && level == edge_sel_l_reg) begin
                seen_idle_reg  <= 1'b1;
            end

            if (state_reg == ST_ARMED && state_next == ST_MEASURE) begin
                counter_reg <= '0;
                scaler_reg  <= '0;
                ovf_int_reg <= 1'b0;
            end else if (state_reg == ST_MEASURE) begin
                scaler_reg  <= tick ? '0 : scaler_reg + SCALE_W'(1);
                counter_reg <= counter_now;
                if (count_sat) ovf_int_reg <= 1'b1;
                if (state_next == ST_HOLD) begin
                    cap_value_reg <= counter_now;
                    cap_ovf_reg   <= ovf_int_reg | count_sat;
                end
            end
        end
    end

    assign busy      = (state_reg == ST_MEASURE);
    assign cap_valid = (state_reg == ST_HOLD);
    assign cap_value = cap_value_reg;
    assign cap_ovf   = cap_ovf_reg;

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture: expected captures are queued as pulses are
// driven and compared when the DUT completes a valid/ready transfer.
module tb_pulse_capture;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [1:0]  ps;
    logic        edge_sel;
    logic        sig_in;
    logic        busy;
    logic        cap_valid;
    logic        cap_ready;
    logic [15:0] cap_value;
    logic        cap_ovf;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;
    int busy_cnt    = 0;
    int valid_cnt   = 0;
    int xfer_cnt    = 0;

    logic [16:0] exp_q[$];

    pulse_capture #(
        .COUNT_BITS (16),
        .SCALER_BITS(2),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .ps       (ps),
        .edge_sel (edge_sel),
        .sig_in   (sig_in),
        .busy     (busy),
        .cap_valid(cap_valid),
        .cap_ready(cap_ready),
        .cap_value(cap_value),
        .cap_ovf  (cap_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) begin
            pass_count++;
        end else begin
            fail_count++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds sig_in at 'lvl' for n sampled cycles, then returns it to the opposite level.
    task automatic pulse(input logic lvl, input int n);
        sig_in = lvl;
        step(n);
        sig_in = ~lvl;
    endtask

    // Scoreboard side: every completed transfer must match the oldest queued result.
    always @(negedge clk) begin
        logic [16:0] e;
        if (busy === 1'b1) busy_cnt++;
        if (cap_valid === 1'b1) valid_cnt++;
        if (cap_valid === 1'b1 && cap_ready === 1'b1) begin
            xfer_cnt++;
            $display("capture value=%0d ovf=%0b", cap_value, cap_ovf);
            chk("capture_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("cap_value", 32'(cap_value), 32'(e[15:0]));
                chk("cap_ovf", 32'(cap_ovf), 32'(e[16]));
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        ps        = 2'd0;
        edge_sel  = 1'b0;
        sig_in    = 1'b0;
        cap_ready = 1'b1;
        step(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(cap_valid), 32'd0);
        chk("rst_value", 32'(cap_value), 32'd0);
        chk("rst_ovf", 32'(cap_ovf), 32'd0);

        // 1: ps=0, 10-cycle high pulse
        reset_n = 1'b1;
        enable  = 1'b1;
        step(5);
        busy_cnt  = 0;
        valid_cnt = 0;
        exp_q.push_back({1'b0, 16'd10});
        pulse(1'b1, 10);
        step(8);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd10);
        chk("t1_valid_cycles", 32'(valid_cnt), 32'd1);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // 2: prescaled 37-cycle pulse at ps=2 and ps=3
        enable = 1'b0; ps = 2'd2; step(2);
        enable = 1'b1; step(5);
        exp_q.push_back({1'b0, 16'd9});
        pulse(1'b1, 37);
        step(8);
        chk("t2_ps2_drained", 32'(exp_q.size()), 32'd0);
        enable = 1'b0; ps = 2'd3; step(2);
        enable = 1'b1; step(5);
        exp_q.push_back({1'b0, 16'd4});
        pulse(1'b1, 37);
        step(8);
        chk("t2_ps3_drained", 32'(exp_q.size()), 32'd0);

        // 3: saturation, then a normal pulse clears the overflow flag
        enable = 1'b0; ps = 2'd0; step(2);
        enable = 1'b1; step(5);
        exp_q.push_back({1'b1, 16'hFFFF});
        pulse(1'b1, 70000);
        step(8);
        chk("t3_sat_drained", 32'(exp_q.size()), 32'd0);
        exp_q.push_back({1'b0, 16'd5});
        pulse(1'b1, 5);
        step(8);
        chk("t3_after_drained", 32'(exp_q.size()), 32'd0);

        // 4: backpressure; pulses during HOLD are ignored
        cap_ready = 1'b0;
        exp_q.push_back({1'b0, 16'd8});
        pulse(1'b1, 8);
        step(6);
        chk("t4_hold_valid", 32'(cap_valid), 32'd1);
        chk("t4_hold_value", 32'(cap_value), 32'd8);
        step(2);
        pulse(1'b1, 3);
        step(6);
        chk("t4_still_valid", 32'(cap_valid), 32'd1);
        chk("t4_still_value", 32'(cap_value), 32'd8);
        chk("t4_still_ovf", 32'(cap_ovf), 32'd0);
        xfer_cnt  = 0;
        cap_ready = 1'b1;
        step(5);
        chk("t4_one_xfer", 32'(xfer_cnt), 32'd1);
        chk("t4_valid_dropped", 32'(cap_valid), 32'd0);
        exp_q.push_back({1'b0, 16'd6});
        pulse(1'b1, 6);
        step(8);
        chk("t4_third_drained", 32'(exp_q.size()), 32'd0);

        // 5: low pulse with edge_sel=1
        enable = 1'b0; edge_sel = 1'b1; sig_in = 1'b1; step(6);
        enable = 1'b1; step(5);
        exp_q.push_back({1'b0, 16'd5});
        pulse(1'b0, 5);
        step(8);
        chk("t5_low_drained", 32'(exp_q.size()), 32'd0);

        // 5b: line active through reset must not give a false start
        reset_n = 1'b0; enable = 1'b0; edge_sel = 1'b0; sig_in = 1'b1;
        step(3);
        reset_n = 1'b1;
        step(6);
        enable = 1'b1;
        valid_cnt = 0;
        step(10);
        chk("t5_no_false_start", 32'(valid_cnt), 32'd0);
        chk("t5_not_busy", 32'(busy), 32'd0);
        sig_in = 1'b0;
        step(3);
        exp_q.push_back({1'b0, 16'd4});
        pulse(1'b1, 4);
        step(8);
        chk("t5_rearm_drained", 32'(exp_q.size()), 32'd0);

        // 6: enable dropped mid-pulse discards the measurement
        valid_cnt = 0;
        sig_in = 1'b1;
        step(4);
        chk("t6_busy_before", 32'(busy), 32'd1);
        enable = 1'b0;
        step(1);
        chk("t6_busy_after", 32'(busy), 32'd0);
        step(15);
        sig_in = 1'b0;
        step(6);
        chk("t6_no_capture", 32'(valid_cnt), 32'd0);

        // 6b: reset mid-MEASURE clears everything
        enable = 1'b1;
        step(4);
        sig_in = 1'b1;
        step(6);
        chk("t6_measuring", 32'(busy), 32'd1);
        reset_n = 1'b0;
        enable  = 1'b0;
        step(1);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_valid", 32'(cap_valid), 32'd0);
        chk("t6_rst_value", 32'(cap_value), 32'd0);
        chk("t6_rst_ovf", 32'(cap_ovf), 32'd0);
        reset_n = 1'b1;
        sig_in  = 1'b0;
        step(6);
        chk("t6_rst_no_capture", 32'(valid_cnt), 32'd0);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
